// File: rtl/riscv_hazard_sb.sv
// riscv_hazard_sb -- register scoreboard and pipeline hazard controller.
//
// Purpose:
//   Tracks in-flight register writes. Each register has a busy flag and a
//   remaining-latency counter. It turns D-stage source lookups, jumps,
//   taken branches and bus waits into pipeline stall and flush controls.
//   A dispatch with latency 0 is a variable-latency op. Its register stays
//   busy until i_lo_done names it.
//
// Build option:
//   RISCV_HAZARD_FWD_EN - when defined, a source whose producer has one
//   cycle left is taken from the bypass network (o_fwdN=1) and does not
//   stall. When undefined, o_fwd1/o_fwd2 are tied low, and any busy
//   source stalls until its busy flag clears.
//
// Ports:
//   clk, rst_n                    clock, synchronous active-low reset
//   i_src1_en/addr, i_src2_en/addr  D-stage source operands
//   i_issue                       valid instruction in D
//   i_dst_en/addr, i_dst_lat      D-stage destination, cycles to writeback
//   i_lo_done, i_lo_addr          variable-latency completion
//   i_jalD, i_ex_branchE          jump in D, taken branch in E
//   i_bus_stallM                  bus wait in M
//   o_stallF..o_stallMB           per-stage hold (active high)
//   o_flushFD, o_flushDE          bubble insert (active high)
//   o_fwd1, o_fwd2                source comes from the bypass network
//   o_busy                        registered scoreboard busy vector

module riscv_hazard_sb #(
    parameter int NREG  = 32,
    parameter int LAT_W = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_src1_en,
    input  logic                     i_src2_en,
    input  logic [$clog2(NREG)-1:0]  i_src1_addr,
    input  logic [$clog2(NREG)-1:0]  i_src2_addr,
    input  logic                     i_issue,
    input  logic                     i_dst_en,
    input  logic [$clog2(NREG)-1:0]  i_dst_addr,
    input  logic [LAT_W-1:0]         i_dst_lat,
    input  logic                     i_lo_done,
    input  logic [$clog2(NREG)-1:0]  i_lo_addr,
    input  logic                     i_jalD,
    input  logic                     i_ex_branchE,
    input  logic                     i_bus_stallM,
    output logic                     o_stallF,
    output logic                     o_stallFD,
    output logic                     o_stallDE,
    output logic                     o_stallEM,
    output logic                     o_stallMB,
    output logic                     o_flushFD,
    output logic                     o_flushDE,
    output logic                     o_fwd1,
    output logic                     o_fwd2,
    output logic [NREG-1:0]          o_busy
);

    localparam int AW = $clog2(NREG);

    logic [NREG-1:0]  r_busy;
    logic [LAT_W-1:0] r_cnt [NREG];
    logic [NREG-1:0]  w_busy_next;
    logic [LAT_W-1:0] w_cnt_next [NREG];

    logic w_src1_live, w_src2_live;
    logic w_fwd1, w_fwd2;
    logic w_haz1, w_haz2, w_hazard;
    logic w_accept, w_set;

    // A source is "live" when it reads a real register that is still being produced.
    assign w_src1_live = i_src1_en & (i_src1_addr != '0) & r_busy[i_src1_addr];
    assign w_src2_live = i_src2_en & (i_src2_addr != '0) & r_busy[i_src2_addr];

`ifdef RISCV_HAZARD_FWD_EN
    // cnt==1 means the producer writes back at the next edge. Its result is
    // already on the bypass network in the cycle the consumer needs it.
    assign w_fwd1 = w_src1_live & (r_cnt[i_src1_addr] == LAT_W'(1));
    assign w_fwd2 = w_src2_live & (r_cnt[i_src2_addr] == LAT_W'(1));
`else
    assign w_fwd1 = 1'b0;
    assign w_fwd2 = 1'b0;
`endif

    assign w_haz1   = w_src1_live & ~w_fwd1;
    assign w_haz2   = w_src2_live & ~w_fwd2;
    assign w_hazard = w_haz1 | w_haz2;

    // Priority: reset > bus stall > branch > hazard > jal > idle.
    always_comb begin
        o_stallF  = 1'b0;
        o_stallFD = 1'b0;
        o_stallDE = 1'b0;
        o_stallEM = 1'b0;
        o_stallMB = 1'b0;
        o_flushFD = 1'b0;
        o_flushDE = 1'b0;
        o_fwd1    = 1'b0;
        o_fwd2    = 1'b0;
        if (!rst_n || i_bus_stallM) begin
            o_stallF  = 1'b1;
            o_stallFD = 1'b1;
            o_stallDE = 1'b1;
            o_stallEM = 1'b1;
            o_stallMB = 1'b1;
        end else if (i_ex_branchE) begin
            o_flushFD = 1'b1;
            o_flushDE = 1'b1;
        end else if (w_hazard) begin
            o_stallF  = 1'b1;
            o_stallFD = 1'b1;
            o_flushDE = 1'b1;
        end else if (i_jalD) begin
            o_flushFD = 1'b1;
        end
        if (rst_n) begin
            o_fwd1 = w_fwd1;
            o_fwd2 = w_fwd2;
        end
    end

    // An instruction leaves D only when it is neither held nor squashed.
    assign w_accept = i_issue & ~o_stallFD & ~o_flushDE;
    assign w_set    = w_accept & i_dst_en & (i_dst_addr != '0);

    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                // x0 is hardwired and never tracked.
                assign w_busy_next[gi] = 1'b0;
                assign w_cnt_next[gi]  = '0;
            end else begin : g_track
                logic             w_b_next;
                logic [LAT_W-1:0] w_c_next;
                always_comb begin
                    w_b_next = r_busy[gi];
                    w_c_next = r_cnt[gi];
                    if (w_set && (i_dst_addr == AW'(gi))) begin
                        // A new dispatch replaces any older pending write (WAW).
                        w_b_next = 1'b1;
                        w_c_next = i_dst_lat;
                    end else begin
                        if (!i_bus_stallM && r_busy[gi] && (r_cnt[gi] != '0)) begin
                            w_c_next = r_cnt[gi] - LAT_W'(1);
                            if (r_cnt[gi] == LAT_W'(1))
                                w_b_next = 1'b0;
                        end
                        // Only a variable-latency entry (cnt==0) is released by i_lo_done.
                        if (i_lo_done && (i_lo_addr == AW'(gi)) && (r_cnt[gi] == '0))
                            w_b_next = 1'b0;
                    end
                end
                assign w_busy_next[gi] = w_b_next;
                assign w_cnt_next[gi]  = w_c_next;
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_busy <= '0;
            for (int r = 0; r < NREG; r++)
                r_cnt[r] <= '0;
        end else begin
            r_busy <= w_busy_next;
            for (int r = 0; r < NREG; r++)
                r_cnt[r] <= w_cnt_next[r];
        end
    end

    assign o_busy = r_busy;

endmodule

// File: tb/tb_riscv_hazard_sb.sv
// Testbench for riscv_hazard_sb. Directed scenarios with hand-computed
// expectations, then randomized traffic. Every sampled cycle is compared
// against a behavioural scoreboard model.
module tb_riscv_hazard_sb;

    localparam int NREG  = 32;
    localparam int LAT_W = 3;
    localparam int AW    = $clog2(NREG);

    logic              clk = 1'b0;
    logic              rst_n;
    logic              i_src1_en, i_src2_en;
    logic [AW-1:0]     i_src1_addr, i_src2_addr;
    logic              i_issue, i_dst_en;
    logic [AW-1:0]     i_dst_addr;
    logic [LAT_W-1:0]  i_dst_lat;
    logic              i_lo_done;
    logic [AW-1:0]     i_lo_addr;
    logic              i_jalD, i_ex_branchE, i_bus_stallM;
    logic              o_stallF, o_stallFD, o_stallDE, o_stallEM, o_stallMB;
    logic              o_flushFD, o_flushDE, o_fwd1, o_fwd2;
    logic [NREG-1:0]   o_busy;

    always #5 clk = ~clk;

    riscv_hazard_sb #(.NREG(NREG), .LAT_W(LAT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_src1_en(i_src1_en), .i_src2_en(i_src2_en),
        .i_src1_addr(i_src1_addr), .i_src2_addr(i_src2_addr),
        .i_issue(i_issue), .i_dst_en(i_dst_en), .i_dst_addr(i_dst_addr),
        .i_dst_lat(i_dst_lat), .i_lo_done(i_lo_done), .i_lo_addr(i_lo_addr),
        .i_jalD(i_jalD), .i_ex_branchE(i_ex_branchE), .i_bus_stallM(i_bus_stallM),
        .o_stallF(o_stallF), .o_stallFD(o_stallFD), .o_stallDE(o_stallDE),
        .o_stallEM(o_stallEM), .o_stallMB(o_stallMB),
        .o_flushFD(o_flushFD), .o_flushDE(o_flushDE),
        .o_fwd1(o_fwd1), .o_fwd2(o_fwd2), .o_busy(o_busy)
    );

    int total = 0;
    int bad   = 0;

    // Model: cycles left before writeback, plus a flag for "waiting on i_lo_done".
    int m_rem [NREG];
    bit m_var [NREG];

    bit e_stallF, e_stallFD, e_stallDE, e_stallEM, e_stallMB;
    bit e_flushFD, e_flushDE, e_fwd1, e_fwd2;
    logic [NREG-1:0] e_busy;

    function automatic bit m_busy(int r);
        return (r != 0) && ((m_rem[r] > 0) || m_var[r]);
    endfunction

    function automatic bit m_fwd(bit en, int a);
`ifdef RISCV_HAZARD_FWD_EN
        return en && (a != 0) && (m_rem[a] == 1);
`else
        return 1'b0;
`endif
    endfunction

    task automatic compute_expected();
        bit f1, f2, haz;
        f1  = m_fwd(i_src1_en, int'(i_src1_addr));
        f2  = m_fwd(i_src2_en, int'(i_src2_addr));
        haz = (i_src1_en && m_busy(int'(i_src1_addr)) && !f1) ||
              (i_src2_en && m_busy(int'(i_src2_addr)) && !f2);
        {e_stallF, e_stallFD, e_stallDE, e_stallEM, e_stallMB} = 5'b0;
        {e_flushFD, e_flushDE} = 2'b0;
        if (!rst_n || i_bus_stallM)
            {e_stallF, e_stallFD, e_stallDE, e_stallEM, e_stallMB} = 5'b11111;
        else if (i_ex_branchE)
            {e_flushFD, e_flushDE} = 2'b11;
        else if (haz)
            {e_stallF, e_stallFD, e_flushDE} = 3'b111;
        else if (i_jalD)
            e_flushFD = 1'b1;
        e_fwd1 = rst_n && f1;
        e_fwd2 = rst_n && f2;
        for (int r = 0; r < NREG; r++)
            e_busy[r] = m_busy(r);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic sample();
        @(negedge clk);
        compute_expected();
        chk("stallF",  o_stallF,  e_stallF);
        chk("stallFD", o_stallFD, e_stallFD);
        chk("stallDE", o_stallDE, e_stallDE);
        chk("stallEM", o_stallEM, e_stallEM);
        chk("stallMB", o_stallMB, e_stallMB);
        chk("flushFD", o_flushFD, e_flushFD);
        chk("flushDE", o_flushDE, e_flushDE);
        chk("fwd1",    o_fwd1,    e_fwd1);
        chk("fwd2",    o_fwd2,    e_fwd2);
        chk("busy",    o_busy,    e_busy);
    endtask

    task automatic advance();
        bit acc;
        int d;
        compute_expected();
        acc = i_issue && !e_stallFD && !e_flushDE;
        d   = int'(i_dst_addr);
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) begin
                m_rem[r] = 0;
                m_var[r] = 0;
            end
        end else begin
            for (int r = 1; r < NREG; r++) begin
                if (acc && i_dst_en && d == r) begin
                    m_rem[r] = int'(i_dst_lat);
                    m_var[r] = (i_dst_lat == 0);
                end else begin
                    if (!i_bus_stallM && m_rem[r] > 0)
                        m_rem[r] = m_rem[r] - 1;
                    if (i_lo_done && int'(i_lo_addr) == r)
                        m_var[r] = 0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst_n = 1'b1;
        i_src1_en = 0; i_src2_en = 0; i_src1_addr = '0; i_src2_addr = '0;
        i_issue = 0; i_dst_en = 0; i_dst_addr = '0; i_dst_lat = '0;
        i_lo_done = 0; i_lo_addr = '0;
        i_jalD = 0; i_ex_branchE = 0; i_bus_stallM = 0;
    endtask

    task automatic dispatch(input int r, input int lat);
        idle();
        i_issue = 1; i_dst_en = 1; i_dst_addr = AW'(r); i_dst_lat = LAT_W'(lat);
    endtask

    task automatic read1(input int r);
        idle();
        i_issue = 1; i_src1_en = 1; i_src1_addr = AW'(r);
    endtask

    initial begin
        for (int r = 0; r < NREG; r++) begin
            m_rem[r] = 0;
            m_var[r] = 0;
        end
        idle();
        rst_n = 1'b0;
        advance();
        // Reset state, still in reset.
        sample();
        chk("rst_stallF", o_stallF, 1);
        chk("rst_stallMB", o_stallMB, 1);
        chk("rst_flushFD", o_flushFD, 0);
        chk("rst_busy", o_busy, 0);
        advance();
        idle(); sample(); advance();

        // x5 latency 2 read right behind its producer.
        dispatch(5, 2); sample(); chk("a_issue_stallFD", o_stallFD, 0); advance();
        read1(5); sample();
        chk("a_haz_stallFD", o_stallFD, 1); chk("a_haz_flushDE", o_flushDE, 1);
        chk("a_haz_stallDE", o_stallDE, 0); chk("a_busy5", o_busy[5], 1);
        advance();
        sample();
`ifdef RISCV_HAZARD_FWD_EN
        chk("a_fwd1", o_fwd1, 1); chk("a_fwd_stallFD", o_stallFD, 0);
`else
        chk("a_haz2_stallFD", o_stallFD, 1); chk("a_nofwd1", o_fwd1, 0);
`endif
        advance();
        sample(); chk("a_clear_stallFD", o_stallFD, 0); chk("a_clear_busy5", o_busy[5], 0);
        advance();

        // x7 variable latency: held until i_lo_done.
        dispatch(7, 0); sample(); advance();
        idle(); i_issue = 1; i_src2_en = 1; i_src2_addr = AW'(7);
        for (int k = 0; k < 3; k++) begin
            sample(); chk("b_wait_stallFD", o_stallFD, 1); advance();
        end
        i_lo_done = 1; i_lo_addr = AW'(7);
        sample(); chk("b_done_stallFD", o_stallFD, 1); advance();
        i_lo_done = 0;
        sample(); chk("b_after_stallFD", o_stallFD, 0); chk("b_busy7", o_busy[7], 0);
        advance();

        // Hazard on x3 coincident with a taken branch.
        dispatch(3, 3); sample(); advance();
        read1(3); i_ex_branchE = 1; sample();
        chk("c_flushFD", o_flushFD, 1); chk("c_flushDE", o_flushDE, 1);
        chk("c_stallFD", o_stallFD, 0); chk("c_stallF", o_stallF, 0);
        advance();
        idle();
        for (int k = 0; k < 4; k++) begin sample(); advance(); end

        // Bus stall freezes the x4 counter at 2.
        dispatch(4, 2); sample(); advance();
        read1(4); i_bus_stallM = 1;
        for (int k = 0; k < 4; k++) begin
            sample();
            chk("d_stallF", o_stallF, 1); chk("d_stallMB", o_stallMB, 1);
            chk("d_flushDE", o_flushDE, 0); chk("d_busy4", o_busy[4], 1);
            advance();
        end
        i_bus_stallM = 0;
        sample(); chk("d_cnt2_stallFD", o_stallFD, 1); chk("d_cnt2_busy4", o_busy[4], 1); advance();
        sample(); chk("d_cnt1_busy4", o_busy[4], 1);
`ifdef RISCV_HAZARD_FWD_EN
        chk("d_cnt1_stallFD", o_stallFD, 0);
`else
        chk("d_cnt1_stallFD", o_stallFD, 1);
`endif
        advance();
        sample(); chk("d_done_busy4", o_busy[4], 0); chk("d_done_stallFD", o_stallFD, 0); advance();

        // x0 is never tracked.
        dispatch(0, 3); sample(); advance();
        read1(0); sample(); chk("e_stallFD", o_stallFD, 0); chk("e_busy", o_busy, 0); advance();

        // Jump alone.
        idle(); i_jalD = 1; sample();
        chk("j_flushFD", o_flushFD, 1); chk("j_flushDE", o_flushDE, 0); chk("j_stallF", o_stallF, 0);
        advance();

        // Reset discards a pending variable-latency x9.
        dispatch(9, 0); sample(); advance();
        idle(); sample(); chk("f_busy9", o_busy[9], 1); advance();
        rst_n = 0; sample(); chk("f_rst_stallEM", o_stallEM, 1); chk("f_rst_flushFD", o_flushFD, 0); advance();
        idle(); sample(); chk("f_busy_cleared", o_busy, 0); advance();
        i_lo_done = 1; i_lo_addr = AW'(9); sample(); advance();
        read1(9); sample(); chk("f_late_stallFD", o_stallFD, 0); chk("f_late_busy9", o_busy[9], 0);
        advance();

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            rst_n        = ($urandom_range(0, 63) != 0);
            i_issue      = ($urandom_range(0, 3) != 0);
            i_dst_en     = ($urandom_range(0, 3) != 0);
            i_dst_addr   = AW'($urandom_range(0, 3) == 0 ? $urandom_range(0, NREG - 1) : $urandom_range(0, 7));
            i_dst_lat    = LAT_W'($urandom_range(0, (1 << LAT_W) - 1));
            i_src1_en    = $urandom_range(0, 1);
            i_src2_en    = $urandom_range(0, 1);
            i_src1_addr  = AW'($urandom_range(0, 7));
            i_src2_addr  = AW'($urandom_range(0, 7));
            i_jalD       = ($urandom_range(0, 7) == 0);
            i_ex_branchE = ($urandom_range(0, 9) == 0);
            i_bus_stallM = ($urandom_range(0, 7) == 0);
            i_lo_done    = ($urandom_range(0, 3) == 0);
            i_lo_addr    = AW'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) begin
                int off;
                off = $urandom_range(0, NREG - 1);
                for (int k = 0; k < NREG; k++)
                    if (m_var[(off + k) % NREG]) begin
                        i_lo_addr = AW'((off + k) % NREG);
                        break;
                    end
            end
            sample();
            advance();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
